// File: rtl/alu_pkg.sv
// Shared constants for the ALU result-select stage: select codes and data width.
package alu_pkg;

  localparam int SEL_W = 4;
  localparam int WIDTH = 8;

  localparam logic [SEL_W-1:0] SEL_A     = 4'd0;
  localparam logic [SEL_W-1:0] SEL_B     = 4'd1;
  localparam logic [SEL_W-1:0] SEL_NEG_A = 4'd2;
  localparam logic [SEL_W-1:0] SEL_NEG_B = 4'd3;
  localparam logic [SEL_W-1:0] SEL_ROR_A = 4'd4;
  localparam logic [SEL_W-1:0] SEL_ROR_B = 4'd5;
  localparam logic [SEL_W-1:0] SEL_LT    = 4'd6;
  localparam logic [SEL_W-1:0] SEL_BIT   = 4'd7;
  localparam logic [SEL_W-1:0] SEL_NOT_A = 4'd8;
  localparam logic [SEL_W-1:0] SEL_NOT_B = 4'd9;
  localparam logic [SEL_W-1:0] SEL_SUB   = 4'd10;
  localparam logic [SEL_W-1:0] SEL_ADD   = 4'd11;

endpackage

// File: rtl/alu_select_if.sv
// Bundle of select code, raw operands, precomputed unit results and the
// registered result bus. master = upstream ALU, slave = result-select stage.
interface alu_select_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);
  import alu_pkg::*;

  logic [SEL_W-1:0] select;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] negative_A;
  logic [WIDTH-1:0] negative_B;
  logic [WIDTH-1:0] ror_A;
  logic [WIDTH-1:0] ror_B;
  logic [WIDTH-1:0] LT;
  logic [WIDTH-1:0] bitwise;
  logic [WIDTH-1:0] not_A;
  logic [WIDTH-1:0] not_B;
  logic [WIDTH-1:0] subtract;
  logic [WIDTH-1:0] add;
  logic [WIDTH-1:0] x;
  logic             sel_illegal;

  modport master (
    output select, a, b, negative_A, negative_B, ror_A, ror_B, LT, bitwise,
           not_A, not_B, subtract, add,
    input  x, sel_illegal
  );

  modport slave (
    input  select, a, b, negative_A, negative_B, ror_A, ror_B, LT, bitwise,
           not_A, not_B, subtract, add,
    output x, sel_illegal
  );

endinterface

// File: rtl/alu_select_mux.sv
// Pure combinational decode of the select code; unused codes give zero and
// raise the illegal flag.
module alu_select_mux #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [alu_pkg::SEL_W-1:0] select,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [WIDTH-1:0]          negative_A,
  input  logic [WIDTH-1:0]          negative_B,
  input  logic [WIDTH-1:0]          ror_A,
  input  logic [WIDTH-1:0]          ror_B,
  input  logic [WIDTH-1:0]          LT,
  input  logic [WIDTH-1:0]          bitwise,
  input  logic [WIDTH-1:0]          not_A,
  input  logic [WIDTH-1:0]          not_B,
  input  logic [WIDTH-1:0]          subtract,
  input  logic [WIDTH-1:0]          add,
  output logic [WIDTH-1:0]          y,
  output logic                      illegal
);
  import alu_pkg::*;

  // Select decode; the default arm also catches X/Z select so nothing latches.
  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (select)
      SEL_A:     y = a;
      SEL_B:     y = b;
      SEL_NEG_A: y = negative_A;
      SEL_NEG_B: y = negative_B;
      SEL_ROR_A: y = ror_A;
      SEL_ROR_B: y = ror_B;
      SEL_LT:    y = LT;
      SEL_BIT:   y = bitwise;
      SEL_NOT_A: y = not_A;
      SEL_NOT_B: y = not_B;
      SEL_SUB:   y = subtract;
      SEL_ADD:   y = add;
      default: begin
        y       = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_select.sv
// ALU result-select stage: decode the select code and register the chosen
// result onto x with one cycle of latency. No path from inputs to x.
module alu_select #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  alu_select_if.slave  bus
);

  logic [WIDTH-1:0] mux_y;
  logic             mux_illegal;

  alu_select_mux #(.WIDTH(WIDTH)) u_mux (
    .select     (bus.select),
    .a          (bus.a),
    .b          (bus.b),
    .negative_A (bus.negative_A),
    .negative_B (bus.negative_B),
    .ror_A      (bus.ror_A),
    .ror_B      (bus.ror_B),
    .LT         (bus.LT),
    .bitwise    (bus.bitwise),
    .not_A      (bus.not_A),
    .not_B      (bus.not_B),
    .subtract   (bus.subtract),
    .add        (bus.add),
    .y          (mux_y),
    .illegal    (mux_illegal)
  );

  // Output register; reset wins over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.x           <= '0;
      bus.sel_illegal <= 1'b0;
    end else begin
      bus.x           <= mux_y;
      bus.sel_illegal <= mux_illegal;
    end
  end

endmodule

// File: tb/tb_alu_select.sv
// Directed bench for alu_select: reset, passthrough, full sweep, unused codes,
// one-cycle latency and mid-stream reset.
module tb_alu_select;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_select_if #(.WIDTH(8)) bus ();

  alu_select #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or re-driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.select = 4'd11;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus.x !== 8'h00 || bus.sel_illegal !== 1'b0) begin
        n_err++;
        $display("FAIL reset[%0d] x=%h ill=%b want x=00 ill=0", i, bus.x, bus.sel_illegal);
      end
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.x !== 8'hE0 || bus.sel_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release x=%h ill=%b want x=e0 ill=0", bus.x, bus.sel_illegal);
    end
  endtask

  task automatic test_passthrough();
    bus.a      = 8'h81;
    bus.b      = 8'h84;
    bus.select = 4'd0;
    tick();
    n_cmp++;
    if (bus.x !== 8'h81 || bus.sel_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL pass_a x=%h ill=%b want x=81 ill=0", bus.x, bus.sel_illegal);
    end
    bus.select = 4'd1;
    tick();
    n_cmp++;
    if (bus.x !== 8'h84 || bus.sel_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL pass_b x=%h ill=%b want x=84 ill=0", bus.x, bus.sel_illegal);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_tab [0:9];
    exp_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'h80, 8'hC0, 8'hE0};
    for (int i = 0; i < 10; i++) begin
      bus.select = 4'(i + 2);
      // Output must still show the previous capture before the edge.
      #1;
      if (i > 0) begin
        n_cmp++;
        if (bus.x !== exp_tab[i-1]) begin
          n_err++;
          $display("FAIL sweep_hold sel=%0d x=%h want %h", i + 2, bus.x, exp_tab[i-1]);
        end
      end
      tick();
      n_cmp++;
      if (bus.x !== exp_tab[i] || bus.sel_illegal !== 1'b0) begin
        n_err++;
        $display("FAIL sweep sel=%0d x=%h ill=%b want x=%h ill=0", i + 2, bus.x, bus.sel_illegal, exp_tab[i]);
      end
    end
  endtask

  task automatic test_unused();
    for (int s = 12; s < 16; s++) begin
      bus.select = 4'(s);
      tick();
      n_cmp++;
      if (bus.x !== 8'h00 || bus.sel_illegal !== 1'b1) begin
        n_err++;
        $display("FAIL unused sel=%0d x=%h ill=%b want x=00 ill=1", s, bus.x, bus.sel_illegal);
      end
    end
    bus.select = 4'd10;
    tick();
    n_cmp++;
    if (bus.x !== 8'hC0 || bus.sel_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL unused_exit x=%h ill=%b want x=c0 ill=0", bus.x, bus.sel_illegal);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev;
    logic [7:0] want;
    bus.a = 8'hFF;
    bus.b = 8'h41;
    prev  = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      bus.select = 4'(i % 2);
      want       = (i % 2 == 0) ? 8'hFF : 8'h41;
      #1;
      n_cmp++;
      if (bus.x !== prev) begin
        n_err++;
        $display("FAIL b2b_hold[%0d] x=%h want %h", i, bus.x, prev);
      end
      tick();
      n_cmp++;
      if (bus.x !== want) begin
        n_err++;
        $display("FAIL b2b[%0d] x=%h want %h", i, bus.x, want);
      end
      prev = want;
    end
  endtask

  task automatic test_mid_reset();
    bus.select = 4'd8;
    tick();
    n_cmp++;
    if (bus.x !== 8'h7F) begin
      n_err++;
      $display("FAIL mid_pre x=%h want 7f", bus.x);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.x !== 8'h00 || bus.sel_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset x=%h ill=%b want x=00 ill=0", bus.x, bus.sel_illegal);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.x !== 8'h7F || bus.sel_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL mid_resume x=%h ill=%b want x=7f ill=0", bus.x, bus.sel_illegal);
    end
    // Reset must also clear a raised illegal flag.
    bus.select = 4'd13;
    tick();
    n_cmp++;
    if (bus.sel_illegal !== 1'b1) begin
      n_err++;
      $display("FAIL ill_set ill=%b want 1", bus.sel_illegal);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.x !== 8'h00 || bus.sel_illegal !== 1'b0) begin
      n_err++;
      $display("FAIL ill_reset x=%h ill=%b want x=00 ill=0", bus.x, bus.sel_illegal);
    end
    reset = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.select     = 4'd11;
    bus.a          = 8'h00;
    bus.b          = 8'h00;
    bus.negative_A = 8'h01;
    bus.negative_B = 8'h03;
    bus.ror_A      = 8'h07;
    bus.ror_B      = 8'h0F;
    bus.LT         = 8'h1F;
    bus.bitwise    = 8'h3F;
    bus.not_A      = 8'h7F;
    bus.not_B      = 8'h80;
    bus.subtract   = 8'hC0;
    bus.add        = 8'hE0;
    #2;
    test_reset();
    test_passthrough();
    test_sweep();
    test_unused();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
